popcount_stream_accum: RTL and testbench

Streaming stage directly downstream of the 64-bit combinational popcount block. It instantiates popcount_int64 on each accepted input word and registers the 7-bit result. It accumulates per-word counts across a frame delimited by in_last, then presents one frame total on a valid/ready output. It feeds PIM benchmark harnesses that need a bit-count per multi-word vector.

---
 rtl/popcount_stream_accum.sv | 185 ++++++++++++++++++
 tb/tb_popcount_stream_accum.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_stream_accum.sv
// ============================================================================
// Module      : popcount_stream_accum (with helper popcount_int64)
// Description : Streaming frame popcount. Each accepted 64-bit word is
//               popcounted into a one-word stage (S1), then summed into a
//               saturating frame accumulator. The frame total is presented
//               on a valid/ready output when the word marked in_last drains.
//               The output register can reload in the same cycle it is
//               consumed, so single-word frames run at one result per cycle.
// Ports       : clk, rst_n          clock, async active-low reset
//               in_valid/in_ready   input word handshake
//               in_data, in_last    word and end-of-frame marker
//               out_valid/out_ready frame total handshake
//               out_count           saturating frame popcount total
//               out_overflow        accumulator saturated in this frame
//               out_words           (POPCNT_WORD_COUNT_EN only) words/frame
// Options     : `define POPCNT_WORD_COUNT_EN adds out_words [15:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_int64 (
    input  logic [63:0] data,
    output logic [6:0]  count
);
    always_comb begin
        count = 7'd0;
        for (int i = 0; i < 64; i++) begin
            count = count + {6'd0, data[i]};
        end
    end
endmodule

module popcount_stream_accum #(
    parameter int WIDTH     = 64,   // fixed at 64 to match popcount_int64
    parameter int ACC_WIDTH = 32    // legal range 8..32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic                 out_overflow
`ifdef POPCNT_WORD_COUNT_EN
    ,
    output logic [15:0]          out_words
`endif
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [6:0]           w_word_cnt;
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic [6:0]           r_s1_cnt;
    logic                 w_s1_fire;
    logic                 w_last_fire;
    logic                 w_accept;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_sat;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [ACC_WIDTH-1:0] r_out_count;
    logic                 r_out_ovf;

    popcount_int64 u_popcount (
        .data  (in_data),
        .count (w_word_cnt)
    );

    // S1 may drain whenever the output side is not holding an unconsumed
    // total. in_ready depends only on registered state and out_ready, so
    // there is no path from in_valid back to in_ready.
    assign w_s1_fire   = r_s1_valid && ((r_state == ACCUM) || out_ready);
    assign w_last_fire = w_s1_fire && r_s1_last;
    assign in_ready    = !r_s1_valid || w_s1_fire;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cnt   <= 7'd0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= in_last;
            r_s1_cnt   <= w_word_cnt;
        end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // One extra bit catches the carry; with ACC_WIDTH >= 8 a single word
    // (at most 64) can never overshoot past that bit.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_WIDTH-6){1'b0}}, r_s1_cnt};
    assign w_sat     = w_sum_ext[ACC_WIDTH];
    assign w_sum     = w_sat ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_s1_fire) begin
            if (r_s1_last) begin
                r_out_count <= w_sum;
                r_out_ovf   <= r_ovf | w_sat;
                r_acc       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_sat;
            end
        end
    end

    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;

`ifdef POPCNT_WORD_COUNT_EN
    logic [15:0] r_words;
    logic [15:0] r_out_words;
    logic [15:0] w_words_inc;

    assign w_words_inc = (r_words == 16'hFFFF) ? 16'hFFFF : (r_words + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words     <= 16'd0;
            r_out_words <= 16'd0;
        end else if (w_s1_fire) begin
            if (r_s1_last) begin
                r_out_words <= w_words_inc;
                r_words     <= 16'd0;
            end else begin
                r_words <= w_words_inc;
            end
        end
    end

    assign out_words = r_out_words;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A last-fire in HOLD reloads the output register, so the state stays in
    // HOLD even while the previous total is being consumed.
    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        if (r_state == ACCUM) begin
            if (w_last_fire) begin
                w_state_next = HOLD;
            end
        end else begin
            out_valid = 1'b1;
            if (w_last_fire) begin
                w_state_next = HOLD;
            end else if (out_ready) begin
                w_state_next = ACCUM;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_popcount_stream_accum.sv
// ============================================================================
// Module      : tb_popcount_stream_accum
// Description : Self-checking bench for popcount_stream_accum. Two instances
//               (ACC_WIDTH 32 and 8) share one stimulus stream; a frame-level
//               reference model (true bit sum per frame, clamped per width)
//               predicts every total. Directed cases cover reset, latency,
//               backpressure, saturation and mid-frame reset, followed by
//               randomized frames with random output backpressure.
// Options     : honours `define POPCNT_WORD_COUNT_EN (checks out_words).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_popcount_stream_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        rand_ready = 1'b0;

    logic        in_ready32, in_ready8;
    logic        out_valid32, out_valid8;
    logic [31:0] out_count32;
    logic [7:0]  out_count8;
    logic        out_ovf32, out_ovf8;
`ifdef POPCNT_WORD_COUNT_EN
    logic [15:0] out_words32, out_words8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount_stream_accum #(.WIDTH(64), .ACC_WIDTH(32)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready32),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid32),
        .out_ready    (out_ready),
        .out_count    (out_count32),
        .out_overflow (out_ovf32)
`ifdef POPCNT_WORD_COUNT_EN
        ,
        .out_words    (out_words32)
`endif
    );

    popcount_stream_accum #(.WIDTH(64), .ACC_WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready8),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid8),
        .out_ready    (out_ready),
        .out_count    (out_count8),
        .out_overflow (out_ovf8)
`ifdef POPCNT_WORD_COUNT_EN
        ,
        .out_words    (out_words8)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: whole-frame bit totals ----------------
    typedef struct {
        longint unsigned sum;
        int unsigned     words;
    } frame_t;

    frame_t          exp_q[$];
    longint unsigned part_sum   = 0;
    int unsigned     part_words = 0;

    function automatic longint unsigned clamp(input longint unsigned s, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (s > mx) ? mx : s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            part_sum   = 0;
            part_words = 0;
            exp_q.delete();
        end else begin
            check_eq("in_ready_8v32", {63'd0, in_ready8}, {63'd0, in_ready32});
            if (out_valid32 || out_valid8) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_valid", {63'd0, out_valid32 | out_valid8}, 64'd0);
                end else begin
                    frame_t f;
                    f = exp_q[0];
                    check_eq("valid32", {63'd0, out_valid32}, 64'd1);
                    check_eq("valid8", {63'd0, out_valid8}, 64'd1);
                    check_eq("count32", {32'd0, out_count32}, clamp(f.sum, 32));
                    check_eq("ovf32", {63'd0, out_ovf32}, {63'd0, f.sum > clamp(f.sum, 32)});
                    check_eq("count8", {56'd0, out_count8}, clamp(f.sum, 8));
                    check_eq("ovf8", {63'd0, out_ovf8}, {63'd0, f.sum > clamp(f.sum, 8)});
`ifdef POPCNT_WORD_COUNT_EN
                    check_eq("words32", {48'd0, out_words32}, clamp(64'(f.words), 16));
                    check_eq("words8", {48'd0, out_words8}, clamp(64'(f.words), 16));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready32) begin
                part_sum += 64'($countones(in_data));
                part_words++;
                if (in_last) begin
                    exp_q.push_back('{part_sum, part_words});
                    part_sum   = 0;
                    part_words = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_word(input logic [63:0] d, input logic l);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        @(negedge clk);
        while (!in_ready32 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready32) check_eq("in_ready_timeout", {63'd0, in_ready32}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid32) && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_eq("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_out_valid", {63'd0, out_valid32}, 64'd0);
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        case ($urandom_range(0, 4))
            0:       w = '1;
            1:       w = 64'd0;
            2:       w = {$urandom, $urandom} & {$urandom, $urandom};
            default: w = {$urandom, $urandom};
        endcase
        return w;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        // Reset held with a valid input present: nothing may be captured.
        in_valid  = 1'b1;
        in_data   = '1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_out_valid", {63'd0, out_valid32}, 64'd0);
            check_eq("rst_out_count", {32'd0, out_count32}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", {63'd0, in_ready32}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_no_output", {63'd0, out_valid32}, 64'd0);
        end

        // Single all-ones word frame: result visible two edges after accept.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = '1;
        in_last  = 1'b1;
        @(negedge clk);
        check_eq("single_in_ready", {63'd0, in_ready32}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("single_lat_edge1", {63'd0, out_valid32}, 64'd0);
        @(negedge clk);
        check_eq("single_lat_edge2", {63'd0, out_valid32}, 64'd1);
        check_eq("single_count", {32'd0, out_count32}, 64'd64);
        check_eq("single_ovf", {63'd0, out_ovf32}, 64'd0);
        @(negedge clk);
        check_eq("single_pulse_end", {63'd0, out_valid32}, 64'd0);
        wait_drain();

        // Multi-word frame: 1 + 2 + 8.
        drive_word(64'h1, 1'b0);
        drive_word(64'h3, 1'b0);
        drive_word(64'hF0F0_0000_0000_0000, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("multi_count", {32'd0, out_count32}, 64'd11);
`ifdef POPCNT_WORD_COUNT_EN
        check_eq("multi_words", {48'd0, out_words32}, 64'd3);
`endif
        wait_drain();

        // Backpressure across two back-to-back single-word frames.
        out_ready = 1'b0;
        drive_word(64'h7, 1'b1);
        drive_word(64'hFF, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_hold_valid", {63'd0, out_valid32}, 64'd1);
            check_eq("bp_hold_count", {32'd0, out_count32}, 64'd3);
            check_eq("bp_in_ready_low", {63'd0, in_ready32}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_first", {32'd0, out_count32}, 64'd3);
        @(negedge clk);
        check_eq("bp_release_second_valid", {63'd0, out_valid32}, 64'd1);
        check_eq("bp_release_second", {32'd0, out_count32}, 64'd8);
        @(negedge clk);
        check_eq("bp_done", {63'd0, out_valid32}, 64'd0);
        wait_drain();

        // Saturation: 320 bits clamps the 8-bit instance; next frame is clean.
        repeat (4) drive_word('1, 1'b0);
        drive_word('1, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("sat_count8", {56'd0, out_count8}, 64'd255);
        check_eq("sat_ovf8", {63'd0, out_ovf8}, 64'd1);
        check_eq("sat_count32", {32'd0, out_count32}, 64'd320);
        drive_word(64'h1, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("post_sat_count8", {56'd0, out_count8}, 64'd1);
        check_eq("post_sat_ovf8", {63'd0, out_ovf8}, 64'd0);
        wait_drain();

        // Reset in the middle of a frame discards the partial sum.
        drive_word(64'h3FF, 1'b0);
        drive_word(64'hF_FFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_word(64'h1, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("midrst_count", {32'd0, out_count32}, 64'd1);
        check_eq("midrst_valid", {63'd0, out_valid32}, 64'd1);
        wait_drain();

        // Randomized frames with random gaps and output backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                drive_word(rand_word(), (w == len - 1));
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
